pe_mac_au: RTL and testbench

//  - PE arithmetic unit; sits directly downstream of IFPAD (ifmap pixels) and WPAD (weights).
//  - Joins one ifmap stream and one weight stream, multiplies each pixel/weight pair (signed),
//    and accumulates N products into one partial sum (psum).
//  - Hands each psum to the PE psum output path over a valid/ready handshake.

---
 rtl/pe_mac_au.sv | 146 ++++++++++++++
 tb/tb_pe_mac_au.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_au.sv
// PE arithmetic unit: joins ifmap/weight streams, multiplies signed pairs and accumulates N products per psum.
// Define PSUM_SAT_EN to saturate each accumulate instead of wrapping.
module pe_mac_au #(
  parameter int DWd     = 16,
  parameter int ConfDWd = 4,
  parameter int AccWd   = 2*DWd + ConfDWd
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ConfDWd-1:0] i_cont_accLen,
  input  logic               i_cont_start,
  input  logic               i_cont_stall,
  input  logic               i_cont_reset,
  input  logic               i_cont_done,
  input  logic [DWd-1:0]     i_ipix_data,
  input  logic               i_ipix_valid,
  output logic               o_ipix_ready,
  input  logic [DWd-1:0]     i_wpix_data,
  input  logic               i_wpix_valid,
  output logic               o_wpix_ready,
  output logic [AccWd-1:0]   o_psum_data,
  output logic               o_psum_valid,
  input  logic               i_psum_ready
);

  localparam int PrdWd = 2*DWd;
  localparam int CntWd = ConfDWd + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_e;

  state_e                   state_q;
  logic [CntWd-1:0]         len_q;
  logic [CntWd-1:0]         cnt_q;
  logic signed [PrdWd-1:0]  prod_p1_q;
  logic                     vld_p1_q;
  logic signed [AccWd-1:0]  acc_p2_q;
  logic signed [AccWd-1:0]  psum_q;
  logic                     psum_vld_q;

  logic                     rst_all;
  logic                     in_acc;
  logic                     accept;
  logic [CntWd-1:0]         len_cfg_d;
  logic [CntWd-1:0]         cnt_d;
  logic signed [PrdWd-1:0]  ipix_ext;
  logic signed [PrdWd-1:0]  wpix_ext;
  logic signed [PrdWd-1:0]  prod_d;
  logic signed [AccWd-1:0]  acc_sum_d;

  function automatic logic signed [AccWd-1:0] acc_add(
    input logic signed [AccWd-1:0] a,
    input logic signed [PrdWd-1:0] p
  );
`ifdef PSUM_SAT_EN
    logic signed [AccWd:0] s;
    s = $signed({a[AccWd-1], a}) + (AccWd+1)'(p);
    if (s[AccWd] != s[AccWd-1])
      acc_add = s[AccWd] ? {1'b1, {(AccWd-1){1'b0}}} : {1'b0, {(AccWd-1){1'b1}}};
    else
      acc_add = s[AccWd-1:0];
`else
    acc_add = a + AccWd'(p);
`endif
  endfunction

  assign rst_all      = i_rst | i_cont_reset;
  assign in_acc       = (state_q == S_ACC) && !i_cont_stall;
  // A stream is only offered ready when its partner is valid, so pairs are consumed atomically.
  assign o_ipix_ready = in_acc && i_wpix_valid;
  assign o_wpix_ready = in_acc && i_ipix_valid;
  assign accept       = in_acc && i_ipix_valid && i_wpix_valid;

  assign len_cfg_d = (i_cont_accLen == '0) ? {1'b1, {ConfDWd{1'b0}}} : {1'b0, i_cont_accLen};
  assign cnt_d     = cnt_q + CntWd'(1);
  assign ipix_ext  = PrdWd'($signed(i_ipix_data));
  assign wpix_ext  = PrdWd'($signed(i_wpix_data));
  assign prod_d    = ipix_ext * wpix_ext;
  assign acc_sum_d = acc_add(acc_p2_q, prod_p1_q);

  assign o_psum_data  = psum_q;
  assign o_psum_valid = psum_vld_q;

  always_ff @(posedge i_clk) begin
    if (rst_all) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      prod_p1_q  <= '0;
      vld_p1_q   <= 1'b0;
      acc_p2_q   <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
    end else if (!i_cont_stall) begin
      // p1: register the product of the accepted pair
      vld_p1_q <= accept;
      if (accept) prod_p1_q <= prod_d;
      // p2: fold the registered product into the accumulator
      if (vld_p1_q) acc_p2_q <= acc_sum_d;

      case (state_q)
        S_IDLE: begin
          if (i_cont_start) begin
            state_q  <= S_ACC;
            len_q    <= len_cfg_d;
            cnt_q    <= '0;
            acc_p2_q <= '0;
          end
        end
        S_ACC: begin
          if (i_cont_done) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
            acc_p2_q <= '0;
          end else if (accept) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_cont_done) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
            acc_p2_q <= '0;
          end else begin
            state_q    <= S_OUT;
            psum_q     <= acc_sum_d;
            psum_vld_q <= 1'b1;
          end
        end
        S_OUT: begin
          // A finished psum is only released through the handshake, even when done is pending.
          if (i_psum_ready) begin
            psum_vld_q <= 1'b0;
            acc_p2_q   <= '0;
            cnt_q      <= '0;
            state_q    <= i_cont_done ? S_IDLE : S_ACC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_au.sv
// Directed self-checking bench for pe_mac_au: sums, latency, join, backpressure, stall, done and soft reset.
module tb_pe_mac_au;

  logic        clk;
  logic        rst;
  logic [3:0]  accLen;
  logic        start;
  logic        stall;
  logic        creset;
  logic        done;
  logic [15:0] ipix_data;
  logic        ipix_valid;
  logic        ipix_ready;
  logic [15:0] wpix_data;
  logic        wpix_valid;
  logic        wpix_ready;
  logic [35:0] psum_data;
  logic        psum_valid;
  logic        psum_ready;

  int n_cmp = 0;
  int n_err = 0;

  pe_mac_au dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cont_accLen (accLen),
    .i_cont_start  (start),
    .i_cont_stall  (stall),
    .i_cont_reset  (creset),
    .i_cont_done   (done),
    .i_ipix_data   (ipix_data),
    .i_ipix_valid  (ipix_valid),
    .o_ipix_ready  (ipix_ready),
    .i_wpix_data   (wpix_data),
    .i_wpix_valid  (wpix_valid),
    .o_wpix_ready  (wpix_ready),
    .o_psum_data   (psum_data),
    .o_psum_valid  (psum_valid),
    .i_psum_ready  (psum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] len);
    accLen = len;
    start  = 1'b1;
    tick;
    start  = 1'b0;
  endtask

  task automatic pair(input logic signed [15:0] a, input logic signed [15:0] b);
    ipix_data  = a;
    wpix_data  = b;
    ipix_valid = 1'b1;
    wpix_valid = 1'b1;
    #1;
    check("acc_irdy", longint'(ipix_ready), 1);
    check("acc_wrdy", longint'(wpix_ready), 1);
    tick;
  endtask

  function automatic longint psum_s();
    return longint'($signed(psum_data));
  endfunction

  initial begin
    rst = 1'b1; accLen = '0; start = 1'b0; stall = 1'b0; creset = 1'b0; done = 1'b0;
    ipix_data = '0; ipix_valid = 1'b0; wpix_data = '0; wpix_valid = 1'b0; psum_ready = 1'b1;
    tick;
    tick;
    check("rst_irdy", longint'(ipix_ready), 0);
    check("rst_wrdy", longint'(wpix_ready), 0);
    check("rst_vld",  longint'(psum_valid), 0);
    check("rst_data", psum_s(), 0);
    rst = 1'b0;
    tick;

    // accLen=3, back-to-back pairs, latency 2 after the last accept
    do_start(4'd3);
    pair(16'sd2, 16'sd3);
    pair(-16'sd4, 16'sd5);
    pair(16'sd7, 16'sd7);
    #1;
    check("drain_irdy", longint'(ipix_ready), 0);
    check("drain_vld",  longint'(psum_valid), 0);
    tick;
    check("lat_vld",  longint'(psum_valid), 1);
    check("t1_sum",   psum_s(), 35);
    check("out_irdy", longint'(ipix_ready), 0);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t1_hs_vld", longint'(psum_valid), 0);
    ipix_valid = 1'b1; wpix_valid = 1'b1;
    #1;
    check("idle_wrdy", longint'(wpix_ready), 0);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;

    // accLen=0 means 16 products; consumer backpressure with done pending
    psum_ready = 1'b0;
    do_start(4'd0);
    for (int i = 0; i < 16; i++) pair(16'sd32767, 16'sd32767);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;
    check("t2_vld", longint'(psum_valid), 1);
    check("t2_sum", psum_s(), 64'sd17178820624);
    done = 1'b1; ipix_valid = 1'b1; wpix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_vld",  longint'(psum_valid), 1);
      check("hold_data", psum_s(), 64'sd17178820624);
      check("hold_irdy", longint'(ipix_ready), 0);
      tick;
    end
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    psum_ready = 1'b1;
    tick;
    done = 1'b0;
    check("t2_hs_vld", longint'(psum_valid), 0);
    tick;

    // pixel valid alone must not consume anything
    do_start(4'd2);
    ipix_data = 16'sd5; ipix_valid = 1'b1; wpix_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("join_irdy", longint'(ipix_ready), 0);
      tick;
    end
    pair(16'sd5, -16'sd6);
    pair(16'sd10, 16'sd10);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    check("t3_drain_vld", longint'(psum_valid), 0);
    tick;
    check("t3_vld", longint'(psum_valid), 1);
    check("t3_sum", psum_s(), 70);
    done = 1'b1;
    tick;
    done = 1'b0;

    // stall mid-ACC, then done discards the partial psum
    do_start(4'd3);
    pair(16'sd4, 16'sd4);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_irdy", longint'(ipix_ready), 0);
      check("stall_wrdy", longint'(wpix_ready), 0);
      tick;
    end
    stall = 1'b0;
    pair(16'sd5, 16'sd5);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    done = 1'b1;
    tick;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("done_novld", longint'(psum_valid), 0);
      tick;
    end
    ipix_valid = 1'b1; wpix_valid = 1'b1;
    #1;
    check("done_idle_irdy", longint'(ipix_ready), 0);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;
    do_start(4'd2);
    pair(16'sd1, 16'sd1);
    pair(16'sd2, 16'sd2);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;
    check("t4_clr_sum", psum_s(), 5);
    stall = 1'b1;
    tick;
    check("stall_out_vld",  longint'(psum_valid), 1);
    check("stall_out_data", psum_s(), 5);
    stall = 1'b0;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t4_hs_vld", longint'(psum_valid), 0);

    // most negative operands, then soft reset while the psum is waiting
    psum_ready = 1'b0;
    do_start(4'd3);
    for (int i = 0; i < 3; i++) pair(16'sh8000, 16'sh8000);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;
    check("t5_vld", longint'(psum_valid), 1);
    check("t5_sum", psum_s(), 64'sd3221225472);
    creset = 1'b1;
    tick;
    creset = 1'b0;
    check("sreset_vld",  longint'(psum_valid), 0);
    check("sreset_data", psum_s(), 0);
    ipix_valid = 1'b1; wpix_valid = 1'b1;
    #1;
    check("sreset_irdy", longint'(ipix_ready), 0);
    check("sreset_wrdy", longint'(wpix_ready), 0);
    ipix_valid = 1'b0; wpix_valid = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
